seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 5 +
 rtl/seq_divider.sv | 104 ++++++++++
 tb/tb_seq_divider.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: FSM state encoding and default width for the sequential divider.
package seq_divider_pkg;
   localparam int WL_DEFAULT = 32;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring 2*WL/WL unsigned divider, one quotient bit per cycle.
// SEQ_DIVIDER_DIV_ZERO_EN adds div_by_zero and a 1-cycle divide-by-zero fast path.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WL = WL_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2*WL-1:0]   dividend,
   input  logic [WL-1:0]     divisor,
   output logic              busy,
   output logic              done,
   output logic [2*WL-1:0]   quotient,
   output logic [WL-1:0]     remainder
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   ,
   output logic              div_by_zero
`endif
);
   localparam int CW = $clog2(2*WL+1);
   state_e          state_q, state_d;
   logic [2*WL-1:0] dvd_q, dvd_d, quo_q, quo_d;
   logic [WL-1:0]   rem_q, rem_d, div_q, div_d, rmd_q, rmd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dbz_q, dbz_d;
   logic [WL:0]     trial;
   logic [WL-1:0]   diff;
   logic            fits;
   // The dividend register doubles as the quotient shifter: bits leave at the top, quotient bits enter at the bottom.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = 1'b0;
      trial   = {rem_q, dvd_q[2*WL-1]};
      fits    = trial >= {1'b0, div_q};
      diff    = trial[WL-1:0] - div_q;
      if (state_q == RUN) begin
         rem_d = fits ? diff : trial[WL-1:0];
         dvd_d = {dvd_q[2*WL-2:0], fits};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d = DONE;
            quo_d   = dvd_d;
            rmd_d   = rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            if (div_q == '0) begin
               quo_d = '1;
               rmd_d = dvd_q[WL-1:0];
               dbz_d = 1'b1;
            end
`endif
         end
      end else if (start) begin
         state_d = RUN;
         dvd_d   = dividend;
         rem_d   = '0;
         div_d   = divisor;
         cnt_d   = CW'(2*WL);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
         if (divisor == '0) cnt_d = CW'(1);
`endif
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end
   assign busy      = state_q == RUN;
   assign done      = state_q == DONE;
   assign quotient  = quo_q;
   assign remainder = rmd_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   assign div_by_zero = dbz_q;
`else
   logic unused_dbz;
   assign unused_dbz = dbz_q;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table, multi-cycle corner sequences and random ops for seq_divider (WL=8).
module tb_seq_divider;
   localparam int WL = 8;
   logic          clk = 1'b0;
   logic          reset, start;
   logic [15:0]   dividend;
   logic [7:0]    divisor;
   logic          busy, done;
   logic [15:0]   quotient;
   logic [7:0]    remainder;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   logic          div_by_zero;
   localparam bit DBZ = 1'b1;
`else
   localparam bit DBZ = 1'b0;
`endif
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   seq_divider #(.WL(WL)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      , .div_by_zero(div_by_zero)
`endif
   );
   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
   } vec_t;
   vec_t vecs[9];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic launch(input logic [15:0] a, input logic [7:0] b);
      start = 1'b1;
      dividend = a;
      divisor = b;
      cyc();
      start = 1'b0;
      dividend = 16'($urandom);
      divisor = 8'($urandom);
   endtask
   task automatic wait_done(output int lat, output int bcyc);
      lat = 0;
      bcyc = 0;
      while (!done && lat < 200) begin
         if (busy) bcyc++;
         cyc();
         lat++;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: got no done expected done within 200 cycles");
      end
   endtask
   task automatic check_dbz(input string name, input bit exp);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      check(name, 64'(div_by_zero), 64'(exp));
`endif
   endtask
   initial begin
      int lat, bc, exp_lat, ndone;
      logic [15:0] a, eq;
      logic [7:0]  b, er;
      vecs[0] = '{16'd1000,  8'd7,    16'd142,   8'd6};
      vecs[1] = '{16'hFFFF,  8'h01,   16'hFFFF,  8'h00};
      vecs[2] = '{16'hFFFF,  8'hFF,   16'h0101,  8'h00};
      vecs[3] = '{16'd100,   8'd10,   16'd10,    8'd0};
      vecs[4] = '{16'd255,   8'd16,   16'd15,    8'd15};
      vecs[5] = '{16'd0,     8'd5,    16'd0,     8'd0};
      vecs[6] = '{16'h1234,  8'h00,   16'hFFFF,  8'h34};
      vecs[7] = '{16'd12345, 8'd255,  16'd48,    8'd105};
      vecs[8] = '{16'd65535, 8'd254,  16'd258,   8'd3};
      reset = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) cyc();
      check("reset_busy", 64'(busy), 0);
      check("reset_done", 64'(done), 0);
      check("reset_quotient", 64'(quotient), 0);
      check("reset_remainder", 64'(remainder), 0);
      check_dbz("reset_dbz", 1'b0);
      start = 1'b1;
      dividend = 16'd1000;
      divisor = 8'd7;
      cyc();
      check("reset_over_start", 64'(busy), 0);
      reset = 1'b0;
      start = 1'b0;
      cyc();
      for (int i = 0; i < 9; i++) begin
         launch(vecs[i].a, vecs[i].b);
         wait_done(lat, bc);
         exp_lat = (vecs[i].b == 0 && DBZ) ? 1 : 16;
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
         check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(exp_lat));
         check($sformatf("vec%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
         check($sformatf("vec%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
         check_dbz($sformatf("vec%0d_dbz", i), vecs[i].b == 0);
         cyc();
         check($sformatf("vec%0d_done_single", i), 64'(done), 0);
         check_dbz($sformatf("vec%0d_dbz_clear", i), 1'b0);
      end
      launch(16'hFFFF, 8'h01);
      wait_done(lat, bc);
      check("b2b_first_quotient", 64'(quotient), 64'hFFFF);
      check("b2b_first_remainder", 64'(remainder), 0);
      launch(16'hFFFF, 8'hFF);
      check("b2b_restart_busy", 64'(busy), 1);
      check("b2b_hold_quotient", 64'(quotient), 64'hFFFF);
      wait_done(lat, bc);
      check("b2b_latency", 64'(lat), 16);
      check("b2b_quotient", 64'(quotient), 64'h0101);
      check("b2b_remainder", 64'(remainder), 0);
      cyc();
      launch(16'd1000, 8'd7);
      repeat (4) cyc();
      start = 1'b1;
      dividend = 16'd50;
      divisor = 8'd3;
      cyc();
      start = 1'b0;
      wait_done(lat, bc);
      check("ignore_start_latency", 64'(5 + lat), 16);
      check("ignore_start_quotient", 64'(quotient), 142);
      check("ignore_start_remainder", 64'(remainder), 6);
      ndone = 0;
      cyc();
      repeat (40) begin
         if (done) ndone++;
         cyc();
      end
      check("ignore_start_extra_done", 64'(ndone), 0);
      launch(16'd1000, 8'd7);
      repeat (7) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("abort_busy", 64'(busy), 0);
      check("abort_done", 64'(done), 0);
      check("abort_quotient", 64'(quotient), 0);
      check("abort_remainder", 64'(remainder), 0);
      ndone = 0;
      repeat (30) begin
         if (done) ndone++;
         cyc();
      end
      check("abort_no_done", 64'(ndone), 0);
      for (int i = 0; i < 2500; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         eq = (b == 0) ? 16'hFFFF : a / 16'(b);
         er = (b == 0) ? a[7:0] : 8'(a % 16'(b));
         launch(a, b);
         wait_done(lat, bc);
         check($sformatf("rand%0d_%0h_%0h_quotient", i, a, b), 64'(quotient), 64'(eq));
         check($sformatf("rand%0d_%0h_%0h_remainder", i, a, b), 64'(remainder), 64'(er));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
